// File: rtl/poly_add_ctrl.sv
// Sequences C[k] = (A[k] + B[k]) mod q over N coefficients via a shared pipelined adder.
// Optional macro POLY_ADD_STALL_EN adds stall_i, which pauses read issue while in ISSUE.
module poly_add_ctrl #(
  parameter int N       = 256,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int ADD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
`ifdef POLY_ADD_STALL_EN
  input  logic              stall_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [11:0]       rd_data_a_i,
  input  logic [11:0]       rd_data_b_i,
  output logic [11:0]       add_op1_o,
  output logic [11:0]       add_op2_o,
  output logic              add_valid_o,
  input  logic [11:0]       add_result_i,
  input  logic              add_valid_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [11:0]       wr_data_o
);

  // Handshake: none of the interfaces back-pressure; a valid is consumed in the cycle it is high.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] N_CNT = (ADDR_W+1)'(N);

  if (RD_LAT != 1 || ADD_LAT < 1) begin : g_param_check
    $error("poly_add_ctrl supports RD_LAT == 1 and ADD_LAT >= 1 only");
  end

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_en_q, rd_en_d;
  logic              add_valid_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              issue_ok;
  logic              wr_en;

`ifdef POLY_ADD_STALL_EN
  assign issue_ok = !stall_i;
`else
  assign issue_ok = 1'b1;
`endif

  // Results come back in issue order, so the write counter doubles as the address.
  assign wr_en = add_valid_i && (state_q == ISSUE || state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (wr_en) wr_cnt_d = wr_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        // The first read is registered on the accepting edge so it appears in cycle 1.
        if (start_i) begin
          state_d   = ISSUE;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          rd_cnt_d  = {{ADDR_W{1'b0}}, 1'b1};
          wr_cnt_d  = '0;
          busy_d    = 1'b1;
        end
      end
      ISSUE: begin
        if (rd_cnt_q == N_CNT) begin
          state_d = DRAIN;
        end else if (issue_ok) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (wr_cnt_d == N_CNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      rd_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      add_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_addr_q   <= rd_addr_d;
      rd_en_q     <= rd_en_d;
      add_valid_q <= rd_en_q;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign add_op1_o   = rd_data_a_i;
  assign add_op2_o   = rd_data_b_i;
  assign add_valid_o = add_valid_q;
  assign wr_en_o     = wr_en;
  assign wr_addr_o   = wr_cnt_q[ADDR_W-1:0];
  assign wr_data_o   = add_result_i;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Bench for poly_add_ctrl: RAM/adder models, expected write queue and cycle-window checks.
module tb_poly_add_ctrl;

  localparam int N      = 256;
  localparam int ADDR_W = 8;
  localparam int Q      = 3329;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
`ifdef POLY_ADD_STALL_EN
  logic              stall_i;
`endif
  logic              busy_o, done_o, rd_en_o, add_valid_o, wr_en_o;
  logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
  logic [11:0]       rd_data_a, rd_data_b, add_op1_o, add_op2_o, wr_data_o;
  logic [11:0]       s1_r, s2_r;
  logic              s1_v, s2_v;

  logic [11:0] mem_a [N];
  logic [11:0] mem_b [N];
  logic [ADDR_W+11:0] exp_q[$];
  int errors, checks;

  poly_add_ctrl #(.N(N), .ADDR_W(ADDR_W), .RD_LAT(1), .ADD_LAT(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
`ifdef POLY_ADD_STALL_EN
    .stall_i(stall_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .rd_data_a_i(rd_data_a), .rd_data_b_i(rd_data_b),
    .add_op1_o(add_op1_o), .add_op2_o(add_op2_o), .add_valid_o(add_valid_o),
    .add_result_i(s2_r), .add_valid_i(s2_v),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
  );

  // Clock and environment models: synchronous RAMs and a 2-stage modular adder sharing rst.
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rd_en_o) begin
      rd_data_a <= mem_a[rd_addr_o];
      rd_data_b <= mem_b[rd_addr_o];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= add_valid_o;
      s2_v <= s1_v;
    end
    s1_r <= 12'((int'(add_op1_o) + int'(add_op2_o)) % Q);
    s2_r <= s1_r;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin mem_a[k] = 12'(k);  mem_b[k] = 12'(Q - 1 - k); end
        1: begin mem_a[k] = 12'(Q - 1); mem_b[k] = 12'(Q - 1); end
        2: begin mem_a[k] = 12'd0;   mem_b[k] = 12'd0; end
        3: begin mem_a[k] = 12'd1;   mem_b[k] = 12'(Q - 1); end
        default: begin
          mem_a[k] = 12'($urandom_range(0, Q - 1));
          mem_b[k] = 12'($urandom_range(0, Q - 1));
        end
      endcase
    end
  endtask

  // One operation: start in cycle 0, optional stall window, extra start pulses, idle tail.
  task automatic run_op(input int s_from, input int s_to, input int x1, input int x2,
                        input int tail);
    int t, sum, n_rd, n_av, n_wr, n_busy, n_done, done_t;
    int first_rd, first_av, first_wr, last_wr, stalls;
    logic [ADDR_W-1:0] exp_rd;
    logic [ADDR_W+11:0] exp_w;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      sum = (int'(mem_a[k]) + int'(mem_b[k])) % Q;
      exp_q.push_back({k[ADDR_W-1:0], sum[11:0]});
    end
    stalls = (s_from >= 0) ? (s_to - s_from + 1) : 0;
    n_rd = 0; n_av = 0; n_wr = 0; n_busy = 0; n_done = 0; done_t = -1;
    first_rd = -1; first_av = -1; first_wr = -1; last_wr = -1; exp_rd = '0;
    @(posedge clk); #1;
    start_i = 1'b1;
    t = 0;
    while (done_t < 0 || t < done_t + tail) begin
      @(posedge clk); #1;
      t++;
      if (rd_en_o) begin
        n_rd++;
        if (first_rd < 0) first_rd = t;
        check_eq("rd_addr", rd_addr_o, exp_rd);
        exp_rd++;
      end
      if (add_valid_o) begin
        n_av++;
        if (first_av < 0) first_av = t;
      end
      if (wr_en_o) begin
        n_wr++;
        if (first_wr < 0) first_wr = t;
        last_wr = t;
        if (exp_q.size() == 0) check_eq("wr_extra", n_wr, N);
        else begin
          exp_w = exp_q.pop_front();
          check_eq("wr_addr_data", {wr_addr_o, wr_data_o}, exp_w);
        end
      end
      if (busy_o) n_busy++;
      if (done_o) begin
        n_done++;
        if (done_t < 0) done_t = t;
      end
      start_i = (t == x1 || t == x2);
`ifdef POLY_ADD_STALL_EN
      stall_i = (t >= s_from && t <= s_to);
`endif
      if (t > N + 400) begin
        check_eq("timeout", t, N + 400);
        break;
      end
    end
    start_i = 1'b0;
`ifdef POLY_ADD_STALL_EN
    stall_i = 1'b0;
`endif
    check_eq("done_cycle", done_t, N + 4 + stalls);
    check_eq("done_count", n_done, 1);
    check_eq("rd_count", n_rd, N);
    check_eq("add_valid_count", n_av, N);
    check_eq("wr_count", n_wr, N);
    check_eq("busy_cycles", n_busy, N + 3 + stalls);
    check_eq("first_rd", first_rd, 1);
    check_eq("first_add_valid", first_av, 2);
    check_eq("first_wr", first_wr, 4);
    check_eq("last_wr", last_wr, N + 3 + stalls);
    check_eq("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_eq({pfx, "_busy"}, busy_o, 0);
    check_eq({pfx, "_done"}, done_o, 0);
    check_eq({pfx, "_rd_en"}, rd_en_o, 0);
    check_eq({pfx, "_rd_addr"}, rd_addr_o, 0);
    check_eq({pfx, "_add_valid"}, add_valid_o, 0);
    check_eq({pfx, "_wr_en"}, wr_en_o, 0);
    check_eq({pfx, "_wr_addr"}, wr_addr_o, 0);
  endtask

  // Start, pulse rst during cycle rst_at, then confirm the controller stays silent.
  task automatic run_reset(input int rst_at, input int watch);
    int activity;
    @(posedge clk); #1;
    start_i = 1'b1;
    for (int t = 1; t <= rst_at; t++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (t == rst_at) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("midrst");
    activity = 0;
    for (int t = 0; t < watch; t++) begin
      @(posedge clk); #1;
      if (rd_en_o || wr_en_o || busy_o || done_o || add_valid_o) activity++;
    end
    check_eq("post_rst_activity", activity, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start_i = 1'b0;
`ifdef POLY_ADD_STALL_EN
    stall_i = 1'b0;
`endif
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    run_op(-1, -1, -1, -1, 0);
    run_op(-1, -1, -1, -1, 0);
    fill(1);
    run_op(-1, -1, 50, N + 4, 10);
    fill(2);
    run_op(-1, -1, -1, -1, 0);
    fill(3);
    run_op(-1, -1, -1, -1, 0);
    run_reset(100, 20);
    fill(4);
    run_op(-1, -1, -1, -1, 0);
`ifdef POLY_ADD_STALL_EN
    fill(4);
    run_op(10, 19, -1, -1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
